// File: rtl/swipt_pwm_gen.sv
// swipt_pwm_gen: NCO-based multi-phase SWIPT bridge driver with shadowed config and clean stop.
// Define SWIPT_PWM_DEADTIME_EN to add per-channel rising-edge dead time.
module swipt_pwm_gen #(
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned DUTY_W = 12,
    parameter int unsigned NCH    = 4,
    parameter int unsigned DT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  freq,
    input  logic [DUTY_W-1:0] duty,
    input  logic [DT_W-1:0]   dead_time,
    output logic [NCH-1:0]    swipt_out,
    output logic              wrap,
    output logic              running
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_e;

    state_e            state_q;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic [ACC_W-1:0]  freq_act_q;
    logic [ACC_W-1:0]  freq_sh_q;
    logic [DUTY_W-1:0] duty_act_q;
    logic [DUTY_W-1:0] duty_sh_q;
    logic              pend_q;
    logic              wrap_q;
    logic              run_q;
    logic              carry_d;
    logic              live_d;
    logic              apply_d;
    logic              accept_d;
    logic [DUTY_W-1:0] ph_top [NCH];
    logic [NCH-1:0]    raw_d;
    logic [NCH-1:0]    out_q;

    always_comb begin
        {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, freq_act_q};
        // The stopping wrap cycle already drives zeros so outputs end cleanly with the period.
        live_d   = (state_q != IDLE) && !((state_q == STOPPING) && carry_d);
        apply_d  = pend_q && ((state_q == IDLE) || carry_d);
        accept_d = cfg_valid && !pend_q;
    end

    // Channel offsets k*2^ACC_W/NCH only touch the top log2(NCH) accumulator bits,
    // so they can be added straight onto the compare slice (needs NCH <= 2^DUTY_W).
    always_comb begin
        ph_top = '{default: '0};
        raw_d  = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            ph_top[k] = acc_q[ACC_W-1 -: DUTY_W] + DUTY_W'((k << DUTY_W) / NCH);
            raw_d[k]  = live_d && (ph_top[k] < duty_act_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            freq_act_q <= '0;
            duty_act_q <= '0;
            freq_sh_q  <= '0;
            duty_sh_q  <= '0;
            pend_q     <= 1'b0;
            wrap_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (apply_d) begin
                freq_act_q <= freq_sh_q;
                duty_act_q <= duty_sh_q;
                pend_q     <= 1'b0;
            end else if (accept_d) begin
                freq_sh_q <= freq;
                duty_sh_q <= duty;
                pend_q    <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    acc_q <= '0;
                    if (en) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q  <= acc_d;
                    wrap_q <= carry_d;
                    if (!en) begin
                        state_q <= STOPPING;
                    end
                end
                STOPPING: begin
                    wrap_q <= carry_d;
                    if (carry_d) begin
                        state_q <= IDLE;
                        acc_q   <= '0;
                        run_q   <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        if (en) begin
                            state_q <= RUN;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    acc_q   <= '0;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef SWIPT_PWM_DEADTIME_EN
    logic [DT_W-1:0] dt_act_q;
    logic [DT_W-1:0] dt_sh_q;
    logic [DT_W-1:0] cnt_q [NCH];
    logic [DT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]  out_d;

    // cnt_q holds how many earlier consecutive cycles raw has been high (saturating),
    // so a pulse shorter than the dead time never reaches the output.
    always_comb begin
        cnt_d = '{default: '0};
        out_d = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (raw_d[k]) begin
                cnt_d[k] = (cnt_q[k] == '1) ? cnt_q[k] : cnt_q[k] + DT_W'(1);
            end
            out_d[k] = raw_d[k] && (cnt_q[k] >= dt_act_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dt_act_q <= '0;
            dt_sh_q  <= '0;
            cnt_q    <= '{default: '0};
            out_q    <= '0;
        end else begin
            if (apply_d) begin
                dt_act_q <= dt_sh_q;
            end else if (accept_d) begin
                dt_sh_q <= dead_time;
            end
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end
`else
    logic unused_dt;
    assign unused_dt = ^dead_time;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= raw_d;
        end
    end
`endif

    assign cfg_ready = ~pend_q;
    assign swipt_out = out_q;
    assign wrap      = wrap_q;
    assign running   = run_q;

endmodule
